// File: rtl/reg_text_buffer.sv
// Double-buffered 8x8 character grid showing a snapshot of the register file as "Rn: HHHH".
// The back bank is formatted one cell per cycle and swapped to the front only on frame_sync.
module reg_text_buffer #(
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned CODE_W     = 6,
   parameter int unsigned CODE_R     = 52,
   parameter int unsigned CODE_COLON = 17,
   parameter int unsigned CODE_SPACE = 18
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REGS*DATA_W-1:0] reg_data,
   input  logic                       refresh,
   input  logic                       frame_sync,
   input  logic [2:0]                 rd_row,
   input  logic [2:0]                 rd_col,
   output logic [CODE_W-1:0]          rd_char,
   output logic                       busy,
   output logic                       swap_pending,
   output logic                       swapped
);

   typedef enum logic [1:0] {StIdle, StCapture, StFormat, StWaitSwap} state_e;

   state_e                      state_q, state_d;
   logic [5:0]                  cnt_q, cnt_d;
   logic                        pending_q, pending_d;
   logic                        bank_sel_q, bank_sel_d;
   logic                        front_valid_q, front_valid_d;
   logic                        swapped_q, swapped_d;
   logic [NUM_REGS*DATA_W-1:0]  snap_q, snap_d;
   logic [CODE_W-1:0]           rd_char_q;

   logic                        wr_en;
   logic [CODE_W-1:0]           wr_code;
   logic [2:0]                  wr_row;
   logic [2:0]                  wr_col;
   logic [DATA_W-1:0]           cur_reg;

   // Both banks in one array, addressed {bank, row, col}.
   logic [CODE_W-1:0]           bank_mem [0:127];

   // Character for the cell currently being formatted.
   always_comb begin
      wr_row  = cnt_q[5:3];
      wr_col  = cnt_q[2:0];
      cur_reg = snap_q[{wr_row, 4'h0} +: DATA_W];
      case (wr_col)
         3'd0:    wr_code = CODE_W'(CODE_R);
         3'd1:    wr_code = CODE_W'(wr_row);
         3'd2:    wr_code = CODE_W'(CODE_COLON);
         3'd3:    wr_code = CODE_W'(CODE_SPACE);
         // Columns 4..7 select nibbles 3..0, MSB first.
         default: wr_code = CODE_W'(cur_reg[{~wr_col[1:0], 2'b00} +: 4]);
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pending_d     = pending_q;
      bank_sel_d    = bank_sel_q;
      front_valid_d = front_valid_q;
      swapped_d     = 1'b0;
      snap_d        = snap_q;
      wr_en         = 1'b0;

      // Requests arriving mid-pass collapse into a single deferred refresh.
      if (refresh && (state_q != StIdle)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (refresh || pending_q) begin
               state_d   = StCapture;
               pending_d = 1'b0;
            end
         end
         StCapture: begin
            snap_d  = reg_data;
            cnt_d   = 6'd0;
            state_d = StFormat;
         end
         StFormat: begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
               state_d = StWaitSwap;
            end
         end
         StWaitSwap: begin
            if (frame_sync) begin
               bank_sel_d    = ~bank_sel_q;
               front_valid_d = 1'b1;
               swapped_d     = 1'b1;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= 6'd0;
         pending_q     <= 1'b0;
         bank_sel_q    <= 1'b0;
         front_valid_q <= 1'b0;
         swapped_q     <= 1'b0;
         snap_q        <= '0;
         rd_char_q     <= CODE_W'(CODE_SPACE);
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pending_q     <= pending_d;
         bank_sel_q    <= bank_sel_d;
         front_valid_q <= front_valid_d;
         swapped_q     <= swapped_d;
         snap_q        <= snap_d;
         rd_char_q     <= front_valid_q ? bank_mem[{bank_sel_q, rd_row, rd_col}]
                                        : CODE_W'(CODE_SPACE);
      end
   end

   // Formatting only ever targets the back bank.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         bank_mem[{~bank_sel_q, cnt_q}] <= wr_code;
      end
   end

   assign rd_char      = rd_char_q;
   assign busy         = (state_q == StCapture) || (state_q == StFormat);
   assign swap_pending = (state_q == StWaitSwap);
   assign swapped      = swapped_q;

endmodule

// File: tb/tb_reg_text_buffer.sv
// Randomized bench for reg_text_buffer: a grid-level reference model queues the expected
// outputs per cycle and an independent monitor compares them against the DUT.
module tb_reg_text_buffer;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [127:0] reg_data = '0;
   logic         refresh = 1'b0;
   logic         frame_sync = 1'b0;
   logic [2:0]   rd_row = '0;
   logic [2:0]   rd_col = '0;
   logic [5:0]   rd_char;
   logic         busy;
   logic         swap_pending;
   logic         swapped;

   reg_text_buffer dut (
      .clock        (clock),
      .reset        (reset),
      .reg_data     (reg_data),
      .refresh      (refresh),
      .frame_sync   (frame_sync),
      .rd_row       (rd_row),
      .rd_col       (rd_col),
      .rd_char      (rd_char),
      .busy         (busy),
      .swap_pending (swap_pending),
      .swapped      (swapped)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cyc;
      int ch;
      bit busy;
      bit sp;
      bit sw;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: pass timing as a countdown, the grid as the text it should show.
   int   m_left = 0;
   bit   m_wait = 0;
   bit   m_pend = 0;
   bit   m_fvalid = 0;
   bit   m_sw = 0;
   int   m_snap[8];
   int   m_front[8][8];

   function automatic int fmt_cell(int regv, int row, int col);
      case (col)
         0:       return 52;
         1:       return row;
         2:       return 17;
         3:       return 18;
         default: return (regv >> (4 * (7 - col))) & 15;
      endcase
   endfunction

   task automatic chk(string name, int c, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", name, c, got, want);
      end
   endtask

   // Monitor: one expectation per clock, compared after the edge it describes.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_char", e.cyc, int'(rd_char), e.ch);
            chk("busy", e.cyc, int'(busy), int'(e.busy));
            chk("swap_pending", e.cyc, int'(swap_pending), int'(e.sp));
            chk("swapped", e.cyc, int'(swapped), int'(e.sw));
         end
      end
   end

   // Drive one cycle, predict the result of the coming edge, then advance past it.
   task automatic step(input bit rst, input bit rf, input bit fs, input int row, input int col,
                       input int ovr);
      exp_t e;
      reset      = rst;
      refresh    = rf;
      frame_sync = fs;
      rd_row     = 3'(row);
      rd_col     = 3'(col);
      if (rst) begin
         e.ch = 18;
         m_left = 0; m_wait = 0; m_pend = 0; m_fvalid = 0; m_sw = 0;
      end else begin
         if (ovr >= 0) e.ch = ovr;
         else          e.ch = m_fvalid ? m_front[row][col] : 18;
         m_sw = 0;
         if (m_left > 0) begin
            if (rf) m_pend = 1;
            if (m_left == 65) begin
               for (int r = 0; r < 8; r++) m_snap[r] = int'(reg_data[r*16 +: 16]);
            end
            m_left--;
            if (m_left == 0) m_wait = 1;
         end else if (m_wait) begin
            if (rf) m_pend = 1;
            if (fs) begin
               for (int r = 0; r < 8; r++)
                  for (int c = 0; c < 8; c++) m_front[r][c] = fmt_cell(m_snap[r], r, c);
               m_fvalid = 1;
               m_wait   = 0;
               m_sw     = 1;
            end
         end else if (rf || m_pend) begin
            m_left = 65;
            m_pend = 0;
         end
      end
      e.cyc  = cyc;
      e.busy = (m_left > 0);
      e.sp   = m_wait;
      e.sw   = m_sw;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic idle_reads(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7), -1);
   endtask

   task automatic randomize_regs();
      for (int r = 0; r < 8; r++) reg_data[r*16 +: 16] = 16'($urandom);
   endtask

   int row2_exp[8] = '{52, 2, 17, 18, 10, 3, 15, 0};
   int row0_exp[8] = '{52, 0, 17, 18, 0, 0, 0, 0};

   initial begin
      // Reset, then read (3,5) from the blank front bank.
      step(1, 0, 0, 0, 0, -1);
      step(1, 0, 0, 0, 0, -1);
      step(0, 0, 0, 3, 5, 18);
      idle_reads(4);

      // First pass; reg_data changes during FORMAT must not leak into the result.
      randomize_regs();
      reg_data[2*16 +: 16] = 16'hA3F0;
      reg_data[0 +: 16]    = 16'h0000;
      step(0, 1, 0, 2, 0, -1);
      for (int i = 1; i <= 70; i++) begin
         if (i == 3) randomize_regs();
         step(0, 0, 0, 2, $urandom_range(0, 7), -1);
      end
      step(0, 0, 1, 2, 0, -1);
      for (int c = 0; c < 8; c++) step(0, 0, 0, 2, c, row2_exp[c]);
      for (int c = 0; c < 8; c++) step(0, 0, 0, 0, c, row0_exp[c]);
      idle_reads(5);

      // Repeated refreshes during FORMAT collapse into exactly one follow-up pass.
      randomize_regs();
      step(0, 1, 0, 1, 1, -1);
      for (int i = 0; i < 70; i++) begin
         if (i == 10) randomize_regs();
         step(0, (i == 5) || (i == 20) || (i == 40), 0, $urandom_range(0, 7),
              $urandom_range(0, 7), -1);
      end
      step(0, 0, 1, 4, 4, -1);
      idle_reads(80);
      step(0, 0, 1, 5, 6, -1);
      idle_reads(80);

      // Reset at FORMAT cycle 30 after a completed swap blanks the display.
      randomize_regs();
      step(0, 1, 0, 0, 0, -1);
      idle_reads(31);
      step(1, 0, 0, 0, 0, -1);
      for (int i = 0; i < 64; i++) step(0, 0, (i % 9) == 4, i / 8, i % 8, -1);

      // Randomized traffic, including the refresh/frame_sync collision and occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) randomize_regs();
         step($urandom_range(0, 399) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 7), $urandom_range(0, 7), -1);
      end
      idle_reads(3);

      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
